// File: rtl/cmd_pkg.sv
// Shared command/response word format and the frame checksum helper.
package cmd_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  localparam logic [7:0] RSP_SOF = 8'hA5;

  // XOR of the payload bytes only; the start-of-frame byte never contributes.
  function automatic logic [7:0] csum8(input cmd_packet_t pkt);
    return pkt.opcode ^ pkt.addr ^ pkt.data;
  endfunction

endpackage

// File: rtl/resp_serializer.sv
// Pops one response word at a time and streams it to the UART transmitter
// as SOF, opcode, addr, data and an optional checksum byte.
module resp_serializer
  import cmd_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = RSP_SOF,
  parameter bit         ENABLE_CSUM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsp_valid,
  input  cmd_packet_t rsp_data,
  output logic        rsp_rd_en,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SOF  = 3'd1;
  localparam logic [2:0] OPC  = 3'd2;
  localparam logic [2:0] ADDR = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] CSUM = 3'd5;

  logic [2:0]  state_q, state_d;
  cmd_packet_t frame_q, frame_d;
  logic [15:0] count_q, count_d;
  logic        xfer;

  // The pop is gated by reset so the FIFO never loses a word while held in reset.
  assign rsp_rd_en   = rst && (state_q == IDLE) && rsp_valid;
  assign tx_valid    = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign frame_count = count_q;
  assign xfer        = tx_valid && tx_ready;

  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      SOF:     tx_byte = SOF_BYTE;
      OPC:     tx_byte = frame_q.opcode;
      ADDR:    tx_byte = frame_q.addr;
      DATA:    tx_byte = frame_q.data;
      CSUM:    tx_byte = csum8(frame_q);
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (rsp_rd_en) begin
          frame_d = rsp_data;
          state_d = SOF;
        end
      end
      SOF:  if (xfer) state_d = OPC;
      OPC:  if (xfer) state_d = ADDR;
      ADDR: if (xfer) state_d = DATA;
      DATA: begin
        if (xfer) begin
          if (ENABLE_CSUM) begin
            state_d = CSUM;
          end else begin
            state_d = IDLE;
            count_d = count_q + 16'd1;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/resp_serializer.md
RESP_SERIALIZER -- requirements
Module: resp_serializer

Interface
REQ-001 SHALL have parameter SOF_BYTE, default 8'hA5: start-of-frame byte prefixed to every frame.
REQ-002 SHALL have parameter ENABLE_CSUM, default 1: 1 appends the checksum byte, 0 omits it.
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rsp_valid, input, 1: the response FIFO holds a word.
REQ-006 SHALL have port rsp_data, input, cmd_packet_t (24): show-ahead head word of the response FIFO.
REQ-007 SHALL have port rsp_rd_en, output, 1: one-cycle pop strobe to the response FIFO.
REQ-008 SHALL have port tx_byte, output, 8: byte offered to the UART transmitter.
REQ-009 SHALL have port tx_valid, output, 1: tx_byte is valid.
REQ-010 SHALL have port tx_ready, input, 1: the transmitter accepts tx_byte this cycle.
REQ-011 SHALL have port busy, output, 1: high while a frame is in progress.
REQ-012 SHALL have port frame_count, output, 16: count of completed frames, wrapping.

Function
REQ-013 SHALL implement FSM states IDLE, SOF, OPC, ADDR, DATA, CSUM.
REQ-014 In IDLE, rsp_rd_en SHALL be combinational (state==IDLE && rsp_valid); it is never asserted in any other state.
REQ-015 On a clock edge where rsp_rd_en=1, the block SHALL capture rsp_data into a frame register and move to SOF.
REQ-016 SOF SHALL be offered (tx_valid=1) in the cycle after the pop, so pop-to-first-byte latency is 1 cycle.
REQ-017 The frame byte order SHALL be SOF_BYTE, opcode, addr, data, then csum if ENABLE_CSUM=1.
REQ-018 csum SHALL be opcode ^ addr ^ data, 8 bits; SOF_BYTE is excluded.
REQ-019 A byte SHALL be transferred only on an edge with tx_valid && tx_ready; the state then advances to the next byte.
REQ-020 While tx_valid=1 and tx_ready=0, tx_byte SHALL hold stable and tx_valid SHALL NOT deassert.
REQ-021 tx_valid SHALL be 1 in states SOF through CSUM and 0 in IDLE.
REQ-022 On transfer of the last byte (DATA when ENABLE_CSUM=0, otherwise CSUM), the block SHALL:
- return to IDLE;
- increment frame_count, wrapping 16'hFFFF to 0.
REQ-023 The next pop SHALL occur no earlier than the cycle after the block returns to IDLE, giving a minimum gap of 1 cycle between frames.
REQ-024 Changes on rsp_valid or rsp_data during a frame SHALL be ignored; the frame register holds the frame's bytes.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 tx_byte SHALL read 8'h00 in IDLE.

Reset
REQ-027 While rst=0, asynchronously:
- state=IDLE;
- tx_valid=0, tx_byte=0, rsp_rd_en=0, busy=0, frame_count=0;
- frame register cleared.
REQ-028 Reset mid-frame SHALL abort the frame with no further bytes sent; frame_count SHALL NOT be incremented for the aborted frame.
REQ-029 After rst deasserts, a pending rsp_valid SHALL be popped in the first clocked cycle.

Structure
REQ-030 cmd_pkg SHALL hold:
- cmd_packet_t as packed {opcode[7:0], addr[7:0], data[7:0]};
- the constant RSP_SOF = 8'hA5;
- a function csum8.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 No sub-module SHALL be used; the design is a single FSM plus datapath of about 150-250 lines.

Verification
REQ-033 Single frame: rsp {02,10,5A} with tx_ready=1 -> tx bytes A5,02,10,5A,48; one rsp_rd_en pulse; frame_count=1.
REQ-034 Backpressure: tx_ready=0 for 3 cycles while addr is offered -> tx_byte=10 held stable for 4 cycles, and the byte sequence is unchanged.
REQ-035 Back-to-back: two words queued, {01,00,FF} then {02,01,33} -> exactly 2 pops, bytes A5,01,00,FF,FE,A5,02,01,33,30, frame_count=2.
REQ-036 ENABLE_CSUM=0 with {03,20,11} -> bytes A5,03,20,11; no checksum byte; frame_count=1.
REQ-037 Reset mid-frame: rst=0 while addr is offered -> tx_valid=0 immediately, frame_count=0; after release, a queued word restarts with A5.
REQ-038 Wrap: force frame_count=FFFF, then complete one frame -> frame_count=0000.
